// File: rtl/svc_pix_vga_pkg.sv
// Shared state encoding and the reference 640x480@60 timing for the VGA sync block.
package svc_pix_vga_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT_FRAME,
        ST_RUN,
        ST_RESYNC
    } vga_state_e;

    // Sync windows are half-open: sync is low for start <= count < end.
    localparam int VGA_H_VISIBLE    = 640;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_END   = 752;
    localparam int VGA_H_LINE_END   = 799;
    localparam int VGA_V_VISIBLE    = 480;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_END   = 492;
    localparam int VGA_V_FRAME_END  = 524;

endpackage

// File: rtl/svc_sync_fifo.sv
// Single-clock FIFO with a combinational head; push is accepted when full if a pop happens that cycle.
module svc_sync_fifo #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = count[ADDR_W];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/svc_pix_vga_sync.sv
// Pixel-stream to VGA timing bridge: buffers a frame-marked stream and locks it to the raster.
// Optional SVC_PIX_VGA_SYNC_STATS_EN adds a saturating underflow_count output.
module svc_pix_vga_sync
    import svc_pix_vga_pkg::*;
#(
    parameter int H_WIDTH         = 12,
    parameter int V_WIDTH         = 12,
    parameter int COLOR_WIDTH     = 4,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int PRIME_LEVEL     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_pix_valid,
    output logic                   s_pix_ready,
    input  logic [COLOR_WIDTH-1:0] s_pix_red,
    input  logic [COLOR_WIDTH-1:0] s_pix_grn,
    input  logic [COLOR_WIDTH-1:0] s_pix_blu,
    input  logic                   s_pix_sof,
    input  logic [H_WIDTH-1:0]     h_visible,
    input  logic [H_WIDTH-1:0]     h_sync_start,
    input  logic [H_WIDTH-1:0]     h_sync_end,
    input  logic [H_WIDTH-1:0]     h_line_end,
    input  logic [V_WIDTH-1:0]     v_visible,
    input  logic [V_WIDTH-1:0]     v_sync_start,
    input  logic [V_WIDTH-1:0]     v_sync_end,
    input  logic [V_WIDTH-1:0]     v_frame_end,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic [COLOR_WIDTH-1:0] vga_red,
    output logic [COLOR_WIDTH-1:0] vga_grn,
    output logic [COLOR_WIDTH-1:0] vga_blu,
    output logic                   vga_error
`ifdef SVC_PIX_VGA_SYNC_STATS_EN
    ,
    output logic [15:0]            underflow_count
`endif
);
    localparam int DW = 1 + 3 * COLOR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] PRIME_CNT = (FIFO_ADDR_WIDTH + 1)'(PRIME_LEVEL);

    vga_state_e               state, state_d;
    logic [H_WIDTH-1:0]       h_count;
    logic [V_WIDTH-1:0]       v_count;
    logic [DW-1:0]            head;
    logic                     head_sof;
    logic [COLOR_WIDTH-1:0]   head_red, head_grn, head_blu;
    logic                     full, empty, push, pop;
    logic [FIFO_ADDR_WIDTH:0] count;
    logic                     visible, at_origin, frame_last;
    logic                     pix_ok, underflow, sof_bad, err_clr;

    // Ready is gated by reset so no pixel slips in while the FIFO is being cleared.
    assign s_pix_ready = rst_n && !full;
    assign push        = s_pix_valid && s_pix_ready;
    assign {head_sof, head_red, head_grn, head_blu} = head;

    svc_sync_fifo #(.DATA_W(DW), .ADDR_W(FIFO_ADDR_WIDTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({s_pix_sof, s_pix_red, s_pix_grn, s_pix_blu}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == h_line_end) begin
            h_count <= '0;
            v_count <= (v_count == v_frame_end) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    assign visible    = (h_count < h_visible) && (v_count < v_visible);
    assign at_origin  = (h_count == '0) && (v_count == '0);
    assign frame_last = (h_count == h_line_end) && (v_count == v_frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        pix_ok    = 1'b0;
        underflow = 1'b0;
        sof_bad   = 1'b0;
        err_clr   = 1'b0;
        case (state)
            ST_IDLE, ST_RESYNC: begin
                if (!empty) begin
                    if (head_sof) state_d = ST_PRIME;
                    else          pop     = 1'b1;
                end
            end
            ST_PRIME: begin
                if (count >= PRIME_CNT || full) state_d = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (frame_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (visible) begin
                    if (empty) begin
                        underflow = 1'b1;
                        state_d   = ST_RESYNC;
                    end else begin
                        pop = 1'b1;
                        // A frame marker must land exactly on the raster origin and nowhere else.
                        if (head_sof != at_origin) begin
                            sof_bad = 1'b1;
                            state_d = ST_RESYNC;
                        end else begin
                            pix_ok  = 1'b1;
                            err_clr = at_origin;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_red   <= '0;
            vga_grn   <= '0;
            vga_blu   <= '0;
            vga_error <= 1'b0;
        end else begin
            vga_hsync <= !((h_count >= h_sync_start) && (h_count < h_sync_end));
            vga_vsync <= !((v_count >= v_sync_start) && (v_count < v_sync_end));
            vga_red   <= pix_ok ? head_red : '0;
            vga_grn   <= pix_ok ? head_grn : '0;
            vga_blu   <= pix_ok ? head_blu : '0;
            if (underflow || sof_bad) vga_error <= 1'b1;
            else if (err_clr)         vga_error <= 1'b0;
        end
    end

`ifdef SVC_PIX_VGA_SYNC_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                   underflow_count <= '0;
        else if (underflow && underflow_count != '1) underflow_count <= underflow_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_svc_pix_vga_sync.sv
// Randomized-colour scenarios on a shrunken raster, checked cycle by cycle against a frame-level model.
module tb_svc_pix_vga_sync;
    localparam int CW = 4, DW = 3 * CW;
    localparam int HV = 16, HSS = 18, HSE = 22, HLE = 23;
    localparam int VV = 8,  VSS = 9,  VSE = 10, VFE = 11;
    localparam int HT = HLE + 1, VT = VFE + 1, FPIX = HV * VV, FCYC = HT * VT;
    localparam int MAXI = 1024, MAXD = 8, GAP = 32;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          s_pix_valid = 1'b0, s_pix_ready, s_pix_sof = 1'b0;
    logic [CW-1:0] s_pix_red = '0, s_pix_grn = '0, s_pix_blu = '0;
    logic          vga_hsync, vga_vsync, vga_error;
    logic [CW-1:0] vga_red, vga_grn, vga_blu;
`ifdef SVC_PIX_VGA_SYNC_STATS_EN
    logic [15:0]   underflow_count;
`endif

    svc_pix_vga_sync dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_pix_valid  (s_pix_valid),
        .s_pix_ready  (s_pix_ready),
        .s_pix_red    (s_pix_red),
        .s_pix_grn    (s_pix_grn),
        .s_pix_blu    (s_pix_blu),
        .s_pix_sof    (s_pix_sof),
        .h_visible    (12'(HV)),
        .h_sync_start (12'(HSS)),
        .h_sync_end   (12'(HSE)),
        .h_line_end   (12'(HLE)),
        .v_visible    (12'(VV)),
        .v_sync_start (12'(VSS)),
        .v_sync_end   (12'(VSE)),
        .v_frame_end  (12'(VFE)),
        .vga_hsync    (vga_hsync),
        .vga_vsync    (vga_vsync),
        .vga_red      (vga_red),
        .vga_grn      (vga_grn),
        .vga_blu      (vga_blu),
        .vga_error    (vga_error)
`ifdef SVC_PIX_VGA_SYNC_STATS_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    // Source stream and the raster-frame -> first-stream-item map (-1 = frame expected black).
    bit            it_sof [MAXI];
    logic [DW-1:0] it_col [MAXI];
    int            map_a [MAXD], map_b [MAXD], map_c [MAXD];
    int            sidx = 0, acc_before = 0;
    bit            mon_en = 1'b0, rst_prev = 1'b0;

    int n_chk = 0, n_fail = 0;
    int pos = 0, cur_d = -1, uf_m = 0;
    bit dead = 1'b0, err_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output at a non-reset edge shows raster position pos; stream item k is available
    // only if it was accepted at an earlier edge (acc_before > k).
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_prev) begin
                check("reset_outputs", 32'({vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_error}),
                      32'({2'b11, {DW{1'b0}}, 1'b0}));
                if (!rst_n) check("reset_ready", 32'(s_pix_ready), 32'(0));
                pos = 0; cur_d = -1; dead = 1'b0; err_m = 1'b0; uf_m = 0;
            end else begin
                int h, v, d, k, base;
                logic [DW-1:0] col;
                bit hs, vs;
                h = pos % HT; v = (pos / HT) % VT; d = pos / FCYC;
                pos++;
                if (d != cur_d) begin cur_d = d; dead = 1'b0; end
                base = (d < MAXD) ? map_c[d] : -1;
                col = '0;
                if (h < HV && v < VV && base >= 0 && !dead) begin
                    k = base + v * HV + h;
                    if (acc_before <= k) begin
                        dead = 1'b1; err_m = 1'b1; uf_m++;
                    end else if (it_sof[k] != (h == 0 && v == 0)) begin
                        dead = 1'b1; err_m = 1'b1;
                    end else begin
                        col = it_col[k];
                        if (h == 0 && v == 0) err_m = 1'b0;
                    end
                end
                hs = !(h >= HSS && h < HSE);
                vs = !(v >= VSS && v < VSE);
                check($sformatf("pix f%0d v%0d h%0d", d, v, h),
                      32'({vga_hsync, vga_vsync, vga_red, vga_grn, vga_blu, vga_error}),
                      32'({hs, vs, col, err_m}));
            end
`ifdef SVC_PIX_VGA_SYNC_STATS_EN
            check("underflow_count", 32'(underflow_count), 32'(uf_m));
`endif
        end
        rst_prev = rst_n;
    end

    task automatic run_scn(input int junk, input int delay, input int bad_f,
                           input int gap0, input int gap1, input int rst_at, input int cycles);
        int nitems;
        bit hs, gap;
        nitems = junk + 7 * FPIX;
        for (int i = 0; i < nitems; i++) begin
            int px;
            px = i - junk;
            it_col[i] = (DW)'($urandom);
            it_sof[i] = (i >= junk) && ((px % FPIX == 0) || (px / FPIX == bad_f && px % FPIX == 10));
        end
        map_c = map_a;
        @(posedge clk); #1;
        rst_n = 1'b0; s_pix_valid = 1'b0; sidx = 0; acc_before = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        for (int t = 0; t < cycles; t++) begin
            gap = (gap0 >= 0 && t >= gap0 && t < gap0 + GAP) || (gap1 >= 0 && t >= gap1 && t < gap1 + GAP);
            s_pix_valid = (t >= delay) && !gap && (sidx < nitems);
            if (sidx < nitems) {s_pix_sof, s_pix_red, s_pix_grn, s_pix_blu} = {it_sof[sidx], it_col[sidx]};
            else               {s_pix_sof, s_pix_red, s_pix_grn, s_pix_blu} = '0;
            @(negedge clk);
            hs = s_pix_valid && s_pix_ready;
            @(posedge clk); #1;
            acc_before = sidx;
            if (hs) sidx++;
            if (t + 1 == rst_at) begin
                rst_n = 1'b0;
                repeat (3) begin @(posedge clk); #1; acc_before = sidx; end
                map_c = map_b;
                rst_n = 1'b1;
            end
        end
        mon_en = 1'b0;
    endtask

    initial begin
        // Steady stream: frame 0 black while priming, then stream frames in order.
        map_a = '{-1, 0, 128, 256, -1, -1, -1, -1};
        run_scn(0, 0, -1, -1, -1, -1, 4 * FCYC);
        // 100 unmarked pixels after a late start must be discarded.
        map_a = '{-1, 100, 228, -1, -1, -1, -1, -1};
        run_scn(100, 5, -1, -1, -1, -1, 3 * FCYC);
        // Two source stalls mid-line, each in a different frame, each recovered a frame later.
        map_a = '{-1, 0, 128, 256, 384, 512, -1, -1};
        run_scn(0, 0, -1, 2 * FCYC + 3 * HT + 4, 4 * FCYC + 3 * HT + 4, -1, 6 * FCYC);
        // Stray frame marker at pixel 10 of line 0 of stream frame 1.
        map_a = '{-1, 0, 128, 256, -1, -1, -1, -1};
        run_scn(0, 0, 1, -1, -1, -1, 4 * FCYC);
        // Reset mid line 5 of frame 1; display resumes only at the next marked frame.
        map_a = '{-1, 0, -1, -1, -1, -1, -1, -1};
        map_b = '{-1, 128, 256, -1, -1, -1, -1, -1};
        run_scn(0, 0, -1, -1, -1, FCYC + 5 * HT + 7, FCYC + 5 * HT + 7 + 3 * FCYC);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
